alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit: the single-cycle ALU datapath extended with a W-bit width parameter, an internal HI/LO register pair, signed-overflow detection, and an iterative shift-add multiplier and restoring divider. It sits in the E stage, consumes the `defines2.vh` 5-bit ALU control codes, and stalls the pipeline while a MULT/MULTU/DIV/DIVU is in flight. A flush input cancels the in-flight operation on exceptions.

---
 rtl/alu_mdu.sv | 208 ++++++++++++++++++++
 tb/tb_alu_mdu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with HI/LO registers, signed-overflow detection
// and an iterative multiplier/divider that stalls the pipeline while busy.
module alu_mdu #(
  parameter int W = 32,
  localparam int SW = $clog2(W)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           valid_i,
  input  logic [4:0]     ctrl_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [SW-1:0]  sa_i,
  input  logic           flush_i,
  output logic [W-1:0]   result_o,
  output logic           overflow_o,
  output logic           stall_o,
  output logic           done_o,
  output logic [2*W-1:0] hilo_o
);

  // ALU control codes
  localparam logic [4:0] C_AND   = 5'd0;
  localparam logic [4:0] C_OR    = 5'd1;
  localparam logic [4:0] C_XOR   = 5'd2;
  localparam logic [4:0] C_NOR   = 5'd3;
  localparam logic [4:0] C_LUI   = 5'd4;
  localparam logic [4:0] C_SLL   = 5'd5;
  localparam logic [4:0] C_SRL   = 5'd6;
  localparam logic [4:0] C_SRA   = 5'd7;
  localparam logic [4:0] C_SLLV  = 5'd8;
  localparam logic [4:0] C_SRLV  = 5'd9;
  localparam logic [4:0] C_SRAV  = 5'd10;
  localparam logic [4:0] C_ADD   = 5'd11;
  localparam logic [4:0] C_ADDU  = 5'd12;
  localparam logic [4:0] C_SUB   = 5'd13;
  localparam logic [4:0] C_SUBU  = 5'd14;
  localparam logic [4:0] C_SLT   = 5'd15;
  localparam logic [4:0] C_SLTU  = 5'd16;
  localparam logic [4:0] C_MFHI  = 5'd17;
  localparam logic [4:0] C_MFLO  = 5'd18;
  localparam logic [4:0] C_MTHI  = 5'd19;
  localparam logic [4:0] C_MTLO  = 5'd20;
  localparam logic [4:0] C_MULT  = 5'd21;
  localparam logic [4:0] C_MULTU = 5'd22;
  localparam logic [4:0] C_DIV   = 5'd23;
  localparam logic [4:0] C_DIVU  = 5'd24;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  hi, lo;
  logic [W-1:0]  acc_hi, acc_lo;   // running product halves / remainder+quotient
  logic [W-1:0]  opb;              // multiplicand or divisor magnitude
  logic [SW-1:0] cnt;
  logic          is_div, neg_q, neg_r, div_zero;

  logic          is_md, is_signed, start, last;
  logic [W-1:0]  abs_a, abs_b;
  logic [W-1:0]  sum, diff;

  assign is_md     = (ctrl_i == C_MULT) || (ctrl_i == C_MULTU) ||
                     (ctrl_i == C_DIV)  || (ctrl_i == C_DIVU);
  assign is_signed = (ctrl_i == C_MULT) || (ctrl_i == C_DIV);
  assign start     = (state == S_IDLE) && valid_i && is_md && !flush_i;
  assign last      = (state == S_BUSY) && (cnt == SW'(W - 1));
  assign abs_a     = (is_signed && a_i[W-1]) ? -a_i : a_i;
  assign abs_b     = (is_signed && b_i[W-1]) ? -b_i : b_i;
  assign sum       = a_i + b_i;
  assign diff      = a_i - b_i;

  // One iteration of the shift-add multiplier or restoring divider
  logic [W:0]     mul_sum, div_shift;
  logic [W-1:0]   div_sub, iter_hi, iter_lo;
  logic           div_ge;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, commit_hi, commit_lo;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[W-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_sub   = div_shift[W-1:0] - opb;

  // Next partial result for the active mul/div iteration
  always_comb begin
    iter_hi = mul_sum[W:1];
    iter_lo = {mul_sum[0], acc_lo[W-1:1]};
    if (is_div) begin
      iter_hi = div_ge ? div_sub : div_shift[W-1:0];
      iter_lo = {acc_lo[W-2:0], div_ge};
    end
  end

  assign prod_fix = neg_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
  assign quot_fix = neg_q ? -iter_lo : iter_lo;
  assign rem_fix  = neg_r ? -iter_hi : iter_hi;

  // Sign fix-up on the final iteration; divide by zero keeps raw magnitudes
  always_comb begin
    commit_hi = prod_fix[2*W-1:W];
    commit_lo = prod_fix[W-1:0];
    if (is_div) begin
      commit_hi = div_zero ? iter_hi : rem_fix;
      commit_lo = div_zero ? iter_lo : quot_fix;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next state; flush always returns to idle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_BUSY;
      S_BUSY:  if (last)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush_i) state_next = S_IDLE;
  end

  assign stall_o = start || (state == S_BUSY);
  assign done_o  = (state == S_DONE) && !flush_i;
  assign hilo_o  = {hi, lo};

  // Operand latch at issue and per-cycle iteration while busy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      acc_hi   <= '0;
      acc_lo   <= abs_a;
      opb      <= abs_b;
      cnt      <= '0;
      is_div   <= (ctrl_i == C_DIV) || (ctrl_i == C_DIVU);
      neg_q    <= is_signed && (a_i[W-1] ^ b_i[W-1]);
      neg_r    <= is_signed && a_i[W-1];
      div_zero <= (b_i == '0);
    end else if ((state == S_BUSY) && !flush_i) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
      cnt    <= cnt + 1'b1;
    end
  end

  // HI/LO: mul/div commit or MTHI/MTLO, both suppressed by flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush_i) begin
      if (last) begin
        hi <= commit_hi;
        lo <= commit_lo;
      end else if (valid_i && (ctrl_i == C_MTHI)) begin
        hi <= a_i;
      end else if (valid_i && (ctrl_i == C_MTLO)) begin
        lo <= a_i;
      end
    end
  end

  // Combinational single-cycle result and ADD/SUB overflow
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (ctrl_i)
      C_AND:  result_o = a_i & b_i;
      C_OR:   result_o = a_i | b_i;
      C_XOR:  result_o = a_i ^ b_i;
      C_NOR:  result_o = ~(a_i | b_i);
      C_LUI:  result_o = {b_i[W/2-1:0], {(W/2){1'b0}}};
      C_SLL:  result_o = b_i << sa_i;
      C_SRL:  result_o = b_i >> sa_i;
      C_SRA:  result_o = W'($signed(b_i) >>> sa_i);
      C_SLLV: result_o = b_i << a_i[SW-1:0];
      C_SRLV: result_o = b_i >> a_i[SW-1:0];
      C_SRAV: result_o = W'($signed(b_i) >>> a_i[SW-1:0]);
      C_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      C_ADDU: result_o = sum;
      C_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      C_SUBU: result_o = diff;
      C_SLT:  result_o = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      C_SLTU: result_o = {{(W-1){1'b0}}, a_i < b_i};
      C_MFHI: result_o = hi;
      C_MFLO: result_o = lo;
      default: result_o = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors for alu_mdu, checked every cycle against a
// behavioural model plus hand-computed literal expectations.
module tb_alu_mdu;
  localparam int W = 32;

  localparam logic [4:0] C_AND   = 5'd0;
  localparam logic [4:0] C_OR    = 5'd1;
  localparam logic [4:0] C_XOR   = 5'd2;
  localparam logic [4:0] C_NOR   = 5'd3;
  localparam logic [4:0] C_LUI   = 5'd4;
  localparam logic [4:0] C_SLL   = 5'd5;
  localparam logic [4:0] C_SRL   = 5'd6;
  localparam logic [4:0] C_SRA   = 5'd7;
  localparam logic [4:0] C_SLLV  = 5'd8;
  localparam logic [4:0] C_SRLV  = 5'd9;
  localparam logic [4:0] C_SRAV  = 5'd10;
  localparam logic [4:0] C_ADD   = 5'd11;
  localparam logic [4:0] C_ADDU  = 5'd12;
  localparam logic [4:0] C_SUB   = 5'd13;
  localparam logic [4:0] C_SUBU  = 5'd14;
  localparam logic [4:0] C_SLT   = 5'd15;
  localparam logic [4:0] C_SLTU  = 5'd16;
  localparam logic [4:0] C_MFHI  = 5'd17;
  localparam logic [4:0] C_MFLO  = 5'd18;
  localparam logic [4:0] C_MTHI  = 5'd19;
  localparam logic [4:0] C_MTLO  = 5'd20;
  localparam logic [4:0] C_MULT  = 5'd21;
  localparam logic [4:0] C_MULTU = 5'd22;
  localparam logic [4:0] C_DIV   = 5'd23;
  localparam logic [4:0] C_DIVU  = 5'd24;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i = 1'b0;
  logic [4:0]  ctrl_i = 5'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [4:0]  sa_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic        overflow_o, stall_o, done_o;
  logic [63:0] hilo_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_mdu #(.W(W)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .ctrl_i(ctrl_i),
    .a_i(a_i), .b_i(b_i), .sa_i(sa_i), .flush_i(flush_i),
    .result_o(result_o), .overflow_o(overflow_o), .stall_o(stall_o),
    .done_o(done_o), .hilo_o(hilo_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_md(input logic [4:0] c);
    return (c == C_MULT) || (c == C_MULTU) || (c == C_DIV) || (c == C_DIVU);
  endfunction

  function automatic logic [63:0] md_result(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          x, y;
    x = a;
    y = b;
    case (c)
      C_MULT:  begin sp = longint'(x) * longint'(y); return sp; end
      C_MULTU: begin up = {32'd0, a} * {32'd0, b}; return up; end
      C_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {((x < 0) ? -a : a), 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(x % y), 32'(x / y)};
      end
    endcase
  endfunction

  function automatic logic [31:0] model_result(input logic [4:0] c, input logic [31:0] a,
      input logic [31:0] b, input logic [4:0] sa, input logic [31:0] h, input logic [31:0] l);
    int x, y;
    x = a;
    y = b;
    case (c)
      C_AND:  return a & b;
      C_OR:   return a | b;
      C_XOR:  return a ^ b;
      C_NOR:  return ~(a | b);
      C_LUI:  return b * 32'h1_0000;
      C_SLL:  return b << sa;
      C_SRL:  return b >> sa;
      C_SRA:  return y >>> sa;
      C_SLLV: return b << (a % 32);
      C_SRLV: return b >> (a % 32);
      C_SRAV: return y >>> (a % 32);
      C_ADD, C_ADDU: return a + b;
      C_SUB, C_SUBU: return a - b;
      C_SLT:  return (x < y) ? 32'd1 : 32'd0;
      C_SLTU: return (a < b) ? 32'd1 : 32'd0;
      C_MFHI: return h;
      C_MFLO: return l;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int x, y;
    longint s;
    x = a;
    y = b;
    if (c == C_ADD)      s = longint'(x) + longint'(y);
    else if (c == C_SUB) s = longint'(x) - longint'(y);
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          exp_stall;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else if (flush_i) begin
      m_left <= 0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        {m_hi, m_lo} <= m_pend;
        m_done <= 1'b1;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (valid_i) begin
      if (is_md(ctrl_i)) begin
        m_left <= W;
        m_pend <= md_result(ctrl_i, a_i, b_i);
      end else if (ctrl_i == C_MTHI) m_hi <= a_i;
      else if (ctrl_i == C_MTLO) m_lo <= a_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_stall = (m_left > 0) ||
                  (!m_done && valid_i && is_md(ctrl_i) && !flush_i);
      check("result", 64'(result_o), 64'(model_result(ctrl_i, a_i, b_i, sa_i, m_hi, m_lo)));
      check("overflow", 64'(overflow_o), 64'(model_ovf(ctrl_i, a_i, b_i)));
      check("stall", 64'(stall_o), 64'(exp_stall));
      check("done", 64'(done_o), 64'(m_done && !flush_i));
      check("hilo", hilo_o, {m_hi, m_lo});
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [4:0]  c;
    logic [31:0] a, b;
    logic [4:0]  sa;
    logic [31:0] r;
    logic        o;
  } vec_t;

  vec_t vt [0:18] = '{
    '{C_ADD,  32'h7FFF_FFFF, 32'h1,          5'd0,  32'h8000_0000, 1'b1},
    '{C_ADDU, 32'h7FFF_FFFF, 32'h1,          5'd0,  32'h8000_0000, 1'b0},
    '{C_SUB,  32'h8000_0000, 32'h1,          5'd0,  32'h7FFF_FFFF, 1'b1},
    '{C_ADD,  32'h8000_0000, 32'h8000_0000,  5'd0,  32'h0,         1'b1},
    '{C_SUBU, 32'h5,         32'h7,          5'd0,  32'hFFFF_FFFE, 1'b0},
    '{C_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd0,  32'h00F0_00F0, 1'b0},
    '{C_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd0,  32'hFFF0_FFF0, 1'b0},
    '{C_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd0,  32'hFF00_FF00, 1'b0},
    '{C_NOR,  32'h0,         32'h0,          5'd0,  32'hFFFF_FFFF, 1'b0},
    '{C_LUI,  32'h0,         32'h0000_ABCD,  5'd0,  32'hABCD_0000, 1'b0},
    '{C_SLL,  32'h0,         32'h1,          5'd31, 32'h8000_0000, 1'b0},
    '{C_SRA,  32'h0,         32'h8000_0000,  5'd4,  32'hF800_0000, 1'b0},
    '{C_SRL,  32'h0,         32'h8000_0000,  5'd4,  32'h0800_0000, 1'b0},
    '{C_SRAV, 32'h24,        32'h8000_0000,  5'd0,  32'hF800_0000, 1'b0},
    '{C_SLLV, 32'h23,        32'h1,          5'd0,  32'h8,         1'b0},
    '{C_SRLV, 32'h1,         32'hF0,         5'd0,  32'h78,        1'b0},
    '{C_SLT,  32'hFFFF_FFFF, 32'h1,          5'd0,  32'h1,         1'b0},
    '{C_SLTU, 32'hFFFF_FFFF, 32'h1,          5'd0,  32'h0,         1'b0},
    '{5'd31,  32'h1234,      32'h5678,       5'd3,  32'h0,         1'b0}
  };

  task automatic drive(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
    @(posedge clk); #1;
    valid_i = 1'b1; ctrl_i = c; a_i = a; b_i = b; sa_i = sa; flush_i = 1'b0;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    valid_i = 1'b0; ctrl_i = 5'd0; a_i = '0; b_i = '0; sa_i = '0; flush_i = 1'b0;
  endtask

  task automatic run_md(input string name, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    bit ended;
    n = 0;
    ended = 1'b0;
    drive(c, a, b, 5'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) begin ended = 1'b1; break; end
      n++;
      @(posedge clk); #1;
    end
    check({name, "_ended"}, 64'(ended), 64'(1));
    check({name, "_stall_cycles"}, 64'(n), 64'(33));
    check({name, "_done"}, 64'(done_o), 64'(1));
    check({name, "_hilo"}, hilo_o, {eh, el});
    $display("txn %s a=%h b=%h stall=%0d hilo=%h", name, a, b, n, hilo_o);
    drive(C_MFHI, 32'h0, 32'h0, 5'd0);
    #1 check({name, "_mfhi"}, 64'(result_o), 64'(eh));
    drive(C_MFLO, 32'h0, 32'h0, 5'd0);
    #1 check({name, "_mflo"}, 64'(result_o), 64'(el));
    go_idle();
  endtask

  initial begin
    int dn;
    resetn = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", hilo_o, 64'h0);
    check("reset_stall", 64'(stall_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    resetn = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].c, vt[i].a, vt[i].b, vt[i].sa);
      #1;
      check($sformatf("vec%0d_result", i), 64'(result_o), 64'(vt[i].r));
      check($sformatf("vec%0d_ovf", i), 64'(overflow_o), 64'(vt[i].o));
      $display("txn ctrl=%0d a=%h b=%h sa=%0d result=%h ovf=%b", vt[i].c, vt[i].a, vt[i].b,
               vt[i].sa, result_o, overflow_o);
    end
    go_idle();

    run_md("mult",     C_MULT,  32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu",    C_MULTU, 32'hFFFF_FFFE, 32'h3,          32'h0000_0002, 32'hFFFF_FFFA);
    run_md("div",      C_DIV,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_z",   C_DIVU,  32'h7,         32'h0,          32'h0000_0007, 32'hFFFF_FFFF);
    run_md("div_ovf",  C_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000);
    run_md("divu",     C_DIVU,  32'd100,       32'd7,          32'd2,         32'd14);

    // flush mid-divide
    drive(C_MTHI, 32'h11, 32'h0, 5'd0);
    drive(C_MTLO, 32'h22, 32'h0, 5'd0);
    drive(C_DIVU, 32'd1000, 32'd3, 5'd0);
    repeat (10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    go_idle();
    #1;
    check("flush_stall", 64'(stall_o), 64'(0));
    check("flush_done", 64'(done_o), 64'(0));
    dn = 0;
    repeat (40) begin @(negedge clk); if (done_o) dn++; end
    check("flush_no_done", 64'(dn), 64'(0));
    check("flush_hilo", hilo_o, {32'h11, 32'h22});
    $display("txn flush divu hilo=%h", hilo_o);

    // HI/LO moves
    drive(C_MTHI, 32'h1234_5678, 32'h0, 5'd0);
    drive(C_MFHI, 32'h0, 32'h0, 5'd0);
    #1 check("mthi_mfhi", 64'(result_o), 64'(32'h1234_5678));
    $display("txn mthi/mfhi result=%h", result_o);
    drive(C_MTLO, 32'h999, 32'h0, 5'd0);
    flush_i = 1'b1;
    drive(C_MFLO, 32'h0, 32'h0, 5'd0);
    #1 check("mtlo_flushed", 64'(result_o), 64'(32'h22));
    $display("txn mtlo flushed, mflo result=%h", result_o);
    go_idle();

    // reset during busy
    drive(C_MULT, 32'h1234, 32'h5678, 5'd0);
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    valid_i = 1'b0;
    ctrl_i = 5'd0;
    #1;
    check("rst_mid_hilo", hilo_o, 64'h0);
    check("rst_mid_stall", 64'(stall_o), 64'(0));
    check("rst_mid_done", 64'(done_o), 64'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    dn = 0;
    repeat (40) begin @(negedge clk); if (done_o) dn++; end
    check("rst_no_done", 64'(dn), 64'(0));
    $display("txn reset mid-mult hilo=%h", hilo_o);

    go_idle();
    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
